// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// serializer FSM states.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD    = 3'b000;
    localparam logic [2:0] MODE_LOAD    = 3'b001;
    localparam logic [2:0] MODE_SHL     = 3'b010;
    localparam logic [2:0] MODE_SHR     = 3'b011;
    localparam logic [2:0] MODE_ROL     = 3'b100;
    localparam logic [2:0] MODE_ROR     = 3'b101;
    localparam logic [2:0] MODE_SER_MSB = 3'b110;
    localparam logic [2:0] MODE_SER_LSB = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register. The master drives the
// operation request; the slave (the register) returns contents and status.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);

    logic [2:0]       mode;
    logic [WIDTH-1:0] X;
    logic             sin;
    logic             start;
    logic [WIDTH-1:0] Q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output mode, X, sin, start,
        input  Q, sout, busy, done
    );

    modport slave (
        input  mode, X, sin, start,
        output Q, sout, busy, done
    );

endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: parallel load, shift/rotate in both
// directions, and an auto-serializer that streams a loaded word out on sout.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    univ_shift_reg_if.slave bus
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             dir_r;
    logic             dir_next_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             done_r;
    logic             done_next_s;

    // Next-state and datapath selection; mode/start only matter while idle
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        cnt_next_s   = cnt_r;
        dir_next_s   = dir_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                case (bus.mode)
                    MODE_HOLD: begin
                        q_next_s = q_r;
                    end
                    MODE_LOAD: begin
                        q_next_s = bus.X;
                    end
                    MODE_SHL: begin
                        q_next_s   = {q_r[WIDTH-2:0], bus.sin};
                        dir_next_s = 1'b0;
                    end
                    MODE_SHR: begin
                        q_next_s   = {bus.sin, q_r[WIDTH-1:1]};
                        dir_next_s = 1'b1;
                    end
                    MODE_ROL: begin
                        q_next_s   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                        dir_next_s = 1'b0;
                    end
                    MODE_ROR: begin
                        q_next_s   = {q_r[0], q_r[WIDTH-1:1]};
                        dir_next_s = 1'b1;
                    end
                    MODE_SER_MSB, MODE_SER_LSB: begin
                        if (bus.start) begin
                            state_next_s = ST_SHIFT;
                            q_next_s     = bus.X;
                            cnt_next_s   = {CNT_W{1'b0}};
                            busy_next_s  = 1'b1;
                            dir_next_s   = (bus.mode == MODE_SER_LSB);
                        end else begin
                            q_next_s = q_r;
                        end
                    end
                    default: begin
                        q_next_s = q_r;
                    end
                endcase
            end
            ST_SHIFT: begin
                // Move the word toward the sout end; the final shift leaves Q all-zero
                q_next_s = dir_r ? {1'b0, q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], 1'b0};
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_IDLE;
                    busy_next_s  = 1'b0;
                    done_next_s  = 1'b1;
                    cnt_next_s   = cnt_r;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            cnt_r   <= cnt_next_s;
            dir_r   <= dir_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    assign bus.Q    = q_r;
    assign bus.sout = dir_r ? q_r[0] : q_r[WIDTH-1];
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the 4-bit parallel-in/parallel-out register. Holds a WIDTH-bit word and supports parallel load, manual shift and rotate in both directions, and an auto-serialize mode. In auto-serialize mode the block loads X, then streams it out on sout over WIDTH cycles with busy/done status. It sits between parallel datapath logic and serial links or bit-level consumers.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.

Ports:
clk    input   1          rising-edge clock; the only clock.
rst    input   1          synchronous, active-high reset.
mode   input   3          operation select (encodings in Behaviour).
X      input   WIDTH      parallel input data.
sin    input   1          serial input bit for SHL/SHR.
start  input   1          begins auto-serialize when mode is SER_MSB or SER_LSB.
Q      output  WIDTH      register contents (registered).
sout   output  1          serial output bit (combinational from Q and dir).
busy   output  1          high while auto-serialize is streaming.
done   output  1          one-cycle pulse after the last serialized bit.

Behaviour:
- Reset (rst=1 at a clk edge) has highest priority:
  - Q=0, busy=0, done=0, cnt=0, dir=0 (MSB side), FSM=IDLE.
  - Reset during an active serialization aborts it immediately; done does not pulse.
- Mode encodings (all apply at the clk edge, in IDLE only):
  - 000 HOLD: Q unchanged.
  - 001 LOAD: Q<=X.
  - 010 SHL: Q<={Q[W-2:0],sin}, dir<=0.
  - 011 SHR: Q<={sin,Q[W-1:1]}, dir<=1.
  - 100 ROL: Q<={Q[W-2:0],Q[W-1]}, dir<=0.
  - 101 ROR: Q<={Q[0],Q[W-1:1]}, dir<=1.
  - 110 SER_MSB, 111 SER_LSB: Q holds unless start=1.
- sout = dir ? Q[0] : Q[W-1], at all times.
- start is ignored unless mode is 110/111 and FSM=IDLE.
- FSM has two states: IDLE and SHIFT.
- IDLE -> SHIFT when start=1 and mode=SER_x. On that edge:
  - Q<=X, cnt<=0, busy<=1.
  - dir<=0 for SER_MSB, dir<=1 for SER_LSB.
- In SHIFT:
  - sout presents bit cnt of the word (MSB-first or LSB-first per dir).
  - Each edge shifts Q toward the sout end, zero-filling the vacated bit, and increments cnt.
  - mode, X, sin and start are ignored.
- SHIFT -> IDLE at the edge where cnt==WIDTH-1:
  - busy<=0, done<=1; Q ends all-zero.
  - busy is high for exactly WIDTH cycles, and sout shows all WIDTH bits, one per busy cycle.
- done is high for exactly one cycle, then returns to 0 unless re-pulsed.
- Back-to-back: start may be asserted in the cycle done=1, since the FSM is already IDLE. This gives busy=1 again on the next edge, with a one-cycle busy gap.
- cnt width is $clog2(WIDTH). cnt never wraps past WIDTH-1.
- No combinational path from X or mode to Q; Q, busy and done are all registered.

Decomposition:
- Package univ_shift_pkg holds:
  - mode encodings as localparams MODE_HOLD … MODE_SER_LSB (3-bit);
  - state encodings ST_IDLE and ST_SHIFT.
- Single module, no sub-module: the FSM and shifter are small and tightly coupled.

Test Plan:
- Reset: rst=1 for 2 cycles with X=8'hA5, mode=LOAD -> Q=0, busy=0, done=0, sout=0. Then LOAD -> Q=8'hA5 one edge after rst=0.
- Manual ops (WIDTH=8, Q=8'hA5): SHL sin=1 -> 8'h4B; SHR sin=0 -> 8'h52; ROL -> 8'h4B; ROR -> 8'hD2; HOLD 3 cycles -> Q stable.
- SER_MSB (WIDTH=8): start with X=8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 over 8 busy cycles, then done=1 for 1 cycle with Q=0.
- SER_LSB: same X -> sout sequence 1,0,1,0,0,1,0,1 (LSB first); mode and X toggled mid-stream have no effect.
- Abort and restart: rst=1 on the 3rd busy cycle -> next edge busy=0, done stays 0, Q=0. Also: start in the done cycle with X=8'h3C -> busy re-asserts next edge and the stream starts 0,0,1,1,...
- Ignored start: start=1 with mode=LOAD -> behaves as LOAD, busy stays 0. Repeat at WIDTH=2: SER_MSB with X=2'b10 -> sout 1,0, then done.
